// File: rtl/mux_reg_arbiter.sv
//------------------------------------------------------------------------------
// mux_reg_arbiter : two-requester arbiter owning a W-bit mux-select load register
// Optional: define MUX_REG_ARBITER_FIXED_PRIO_EN for fixed A-over-B priority.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mux_reg_arbiter #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [W-1:0]  a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [W-1:0]  b_data,
    output logic          b_ready,
    output logic [W-1:0]  q,
    output logic          q_valid,
    input  logic          q_ready,
    output logic          s,
    output logic          enable,
    output logic          L,
    output logic [CW-1:0] cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant_a;
    logic   grant_b;
    logic   consume;
    logic   s_hold;
    logic   prio_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are gated by reset so no strobe escapes while reset is held low.
    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                if (reset) begin
                    if (a_valid && (!b_valid || !prio_b)) begin
                        grant_a = 1'b1;
                    end else if (b_valid) begin
                        grant_b = 1'b1;
                    end
                end
                if (grant_a || grant_b) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (q_valid && q_ready) begin
                    consume   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign enable  = grant_a | grant_b;
    assign s       = grant_a ? 1'b1 : (grant_b ? 1'b0 : s_hold);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= '0;
            q_valid <= 1'b0;
            s_hold  <= 1'b1;
            L       <= 1'b0;
            cnt     <= '0;
        end else begin
            if (grant_a) begin
                q       <= a_data;
                L       <= 1'b0;
                s_hold  <= 1'b1;
                q_valid <= 1'b1;
            end else if (grant_b) begin
                q       <= b_data;
                L       <= 1'b1;
                s_hold  <= 1'b0;
                q_valid <= 1'b1;
            end else if (consume) begin
                q_valid <= 1'b0;
                cnt     <= cnt + 1'b1;
            end
        end
    end

`ifdef MUX_REG_ARBITER_FIXED_PRIO_EN
    assign prio_b = 1'b0;
`else
    // Priority points at the requester that lost (or did not take) the last grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_b <= 1'b0;
        end else if (grant_a) begin
            prio_b <= 1'b1;
        end else if (grant_b) begin
            prio_b <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_reg_arbiter.sv
//------------------------------------------------------------------------------
// tb_mux_reg_arbiter : directed + randomized bench with a behavioural model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mux_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, q_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, q_valid, s, enable, L;
    logic [7:0] q;
    logic [3:0] cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    mux_reg_arbiter #(.W(8), .CW(4)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .s       (s),
        .enable  (enable),
        .L       (L),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a one-slot holding register plus a transfer count.
    bit       m_full;
    bit [7:0] m_q;
    bit       m_L, m_s, m_prio_b;
    int       m_cnt;
    logic     e_ga, e_gb;

    always_comb begin
        e_ga = rst_n && !m_full && a_valid && (!b_valid || !m_prio_b);
        e_gb = rst_n && !m_full && b_valid && (!a_valid || m_prio_b);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 0; m_q <= 0; m_L <= 0; m_s <= 1; m_prio_b <= 0; m_cnt <= 0;
        end else if (!m_full) begin
            if (e_ga || e_gb) begin
                m_full <= 1;
                m_q    <= e_ga ? a_data : b_data;
                m_L    <= e_gb;
                m_s    <= e_ga;
`ifndef MUX_REG_ARBITER_FIXED_PRIO_EN
                m_prio_b <= e_ga;
`endif
            end
        end else if (q_ready) begin
            m_full <= 0;
            m_cnt  <= (m_cnt + 1) % 16;
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_q",       q,       m_q);
            chk("cyc_q_valid", q_valid, m_full);
            chk("cyc_L",       L,       m_L);
            chk("cyc_cnt",     cnt,     m_cnt);
            chk("cyc_s",       s,       e_ga ? 1 : (e_gb ? 0 : m_s));
            chk("cyc_a_ready", a_ready, e_ga);
            chk("cyc_b_ready", b_ready, e_gb);
            chk("cyc_enable",  enable,  e_ga | e_gb);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_q [4];
    logic       exp_L [4];

    initial begin
        rst_n = 1; a_valid = 0; b_valid = 0; q_ready = 0; a_data = 0; b_data = 0;
        #1 rst_n = 0;
        a_valid = 1'($urandom); b_valid = 1'($urandom); q_ready = 1'($urandom);
        a_data = 8'($urandom); b_data = 8'($urandom);
        #0.1;
        chk("rst_q", q, 0);        chk("rst_q_valid", q_valid, 0);
        chk("rst_s", s, 1);        chk("rst_L", L, 0);
        chk("rst_cnt", cnt, 0);    chk("rst_enable", enable, 0);
        chk("rst_a_ready", a_ready, 0); chk("rst_b_ready", b_ready, 0);
        chk_en = 1;
        step(); step();

        // Single A transfer
        rst_n = 1; a_valid = 1; a_data = 8'b0101_0101; b_valid = 0; q_ready = 0;
        #1;
        chk("singleA_a_ready", a_ready, 1); chk("singleA_enable", enable, 1); chk("singleA_s", s, 1);
        step(); a_valid = 0; #1;
        chk("singleA_q", q, 8'h55); chk("singleA_q_valid", q_valid, 1);
        chk("singleA_L", L, 0);     chk("singleA_s_held", s, 1);
        step(); step(); q_ready = 1; step(); q_ready = 0;
        chk("singleA_cnt", cnt, 1); chk("singleA_consumed", q_valid, 0); chk("singleA_q_hold", q, 8'h55);

        // Contention from fresh reset
        rst_n = 0; #1 rst_n = 1;
        a_valid = 1; b_valid = 1; a_data = 8'h55; b_data = 8'hFF; q_ready = 1;
`ifdef MUX_REG_ARBITER_FIXED_PRIO_EN
        exp_q = '{8'h55, 8'h55, 8'h55, 8'h55}; exp_L = '{0, 0, 0, 0};
`else
        exp_q = '{8'h55, 8'hFF, 8'h55, 8'hFF}; exp_L = '{0, 1, 0, 1};
`endif
        for (int k = 0; k < 4; k++) begin
            step();
            chk("cont_q", q, exp_q[k]); chk("cont_L", L, exp_L[k]); chk("cont_s", s, !exp_L[k]);
            step();
        end
        a_valid = 0; b_valid = 0;
        chk("cont_cnt", cnt, 4);

        // Backpressure
        b_valid = 1; b_data = 8'hFF; q_ready = 0;
        step();
        b_valid = 0; a_valid = 1; a_data = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            #1; chk("bp_a_ready", a_ready, 0); chk("bp_q", q, 8'hFF);
            step();
        end
        q_ready = 1;
        step(); q_ready = 0;
        chk("bp_a_grant", a_ready, 1);
        step();
        chk("bp_q_after", q, 8'h3C); chk("bp_L_after", L, 0);

        // Asynchronous reset while holding data
        a_valid = 0; q_ready = 1;
        step(); q_ready = 0; b_valid = 1; b_data = 8'hFF;
        step(); b_valid = 0;
        chk("rmid_q_pre", q, 8'hFF); chk("rmid_valid_pre", q_valid, 1);
        #2 rst_n = 0;
        #0.1;
        chk("rmid_q", q, 0); chk("rmid_q_valid", q_valid, 0); chk("rmid_cnt", cnt, 0);
        step(); step();
        rst_n = 1; a_valid = 1; b_valid = 1; a_data = 8'hA7; b_data = 8'h11;
        #1; chk("rmid_a_first", a_ready, 1); chk("rmid_b_wait", b_ready, 0);
        step(); chk("rmid_q_after", q, 8'hA7); chk("rmid_L_after", L, 0);
        a_valid = 0; b_valid = 0;

        // Counter wrap after 16 A transfers
        rst_n = 0; #1 rst_n = 1;
        a_valid = 1; b_valid = 0; q_ready = 1; a_data = 8'($urandom);
        for (int i = 0; i < 32; i++) begin
            step();
            if (i == 29) chk("wrap_cnt15", cnt, 15);
        end
        chk("wrap_cnt0", cnt, 0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 2000; i++) begin
            step();
            rst_n   = ($urandom_range(0, 63) != 0);
            a_valid = 1'($urandom); b_valid = 1'($urandom);
            q_ready = ($urandom_range(0, 3) != 0);
            a_data  = 8'($urandom); b_data = 8'($urandom);
        end
        step();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_reg_arbiter.md
Name: mux_reg_arbiter

Overview:
- Controller and owner of the shared W-bit mux-select load register: two requesters (A, B) compete to load their operand into a single register q.
- The block arbitrates between them, drives the mux select s and load strobe enable, and presents q to one downstream consumer over a valid/ready handshake.
- It sits between the operand sources and the register consumer and is the only agent that drives s and enable.

Parameters:
- W, 8, data width of a_data, b_data, q.
- CW, 4, width of the completed-transfer counter cnt.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- a_valid  input  1  requester A has data.
- a_data  input  W  requester A operand.
- a_ready  output  1  A's operand is captured this cycle.
- b_valid  input  1  requester B has data.
- b_data  input  W  requester B operand.
- b_ready  output  1  B's operand is captured this cycle.
- q  output  W  register contents.
- q_valid  output  1  q holds an unconsumed value.
- q_ready  input  1  consumer accepts q.
- s  output  1  mux select: 1 = A, 0 = B; holds the last grant.
- enable  output  1  register load strobe, 1-cycle pulse.
- L  output  1  source of current q: 0 = A, 1 = B.
- cnt  output  CW  completed consumer transfers, mod 2^CW.

Behaviour:
- Reset (reset=0, asynchronous, immediate on all outputs):
  - state=IDLE, q=0, q_valid=0, s=1, L=0, cnt=0, prio=A.
  - a_ready, b_ready and enable are 0 while reset is low.
- FSM states: IDLE, FULL.
- IDLE:
  - Grant is computed combinationally from a_valid, b_valid and prio.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester pointed to by prio wins.
  - The winner's ready=1 and enable=1 in the same cycle. s is driven combinationally to the winner (1 for A, 0 for B) during the grant cycle, then held registered.
  - At the clock edge: q <= winner data; L <= (winner==B); q_valid <= 1; prio <= the other requester; state <= FULL.
  - If neither is valid: no ready, enable=0, and s, q, L are unchanged.
- FULL:
  - a_ready=b_ready=0 and enable=0; q is stable.
  - When q_valid & q_ready at a clock edge: q_valid <= 0; cnt <= cnt+1 (wraps from 2^CW-1 to 0); state <= IDLE.
  - q keeps its value after consumption.
- Latency:
  - Grant to q_valid is 1 cycle.
  - Minimum period per transfer is 2 cycles (IDLE grant, then FULL accept). No back-to-back grants without an intervening IDLE cycle.
- Fairness:
  - Round-robin under continuous contention: A, B, A, B, ...
  - prio updates only on a grant.
- Boundary conditions:
  - Requester deasserting valid while not granted: no effect.
  - q_ready asserted while q_valid=0: ignored; cnt does not change.
  - cnt wrap is silent; there is no overflow flag.
  - Reset mid-FULL: pending q is discarded (q=0, q_valid=0), cnt=0, prio=A.
  - Simultaneous a_valid and b_valid in the first IDLE cycle after reset: A wins.
- Outputs q, q_valid, L, cnt and the held value of s are registered. a_ready, b_ready, enable and grant-cycle s are combinational from the IDLE state and the valids.

Optional Feature:
- Macro: MUX_REG_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, A always wins contention; prio is not updated. Under continuous contention B is never granted.
- Undefined: round-robin as described above.

Test Plan:
- Reset: hold reset=0 for 100 ps with random inputs -> q=8'h00, q_valid=0, s=1, L=0, cnt=0, enable=0, a_ready=b_ready=0.
- Single A: a_valid=1, a_data=8'b0101_0101, q_ready=0 -> a_ready=enable=1 for 1 cycle; next cycle q=8'h55, q_valid=1, L=0, s=1; q holds until q_ready=1, then cnt=1.
- Contention: a_data=8'h55, b_data=8'hFF, both valid continuously, q_ready=1 -> grants alternate A,B,A,B; q sequence 55,FF,55,FF; L sequence 0,1,0,1; s sequence 1,0,1,0; cnt=4 after 8 cycles (fixed-prio build: 55 ×4, L=0 throughout).
- Backpressure: load 8'hFF from B, keep q_ready=0 for 5 cycles while a_valid=1 -> a_ready=0 throughout, q=8'hFF stable; raise q_ready -> A granted the following cycle.
- Reset mid-operation: q_valid=1 with q=8'hFF, drop reset asynchronously mid-cycle -> q=0 and q_valid=0 immediately; after release, both valid -> A granted first.
- Counter wrap: 16 consecutive A transfers with CW=4 -> cnt returns to 0 after the 16th consumer accept.
